// File: rtl/nebula_credit_rx_buffer.sv
// Receive-side credit-controlled flit buffer for one VC; NEBULA_RX_HWM_EN adds a high-water register.
// Latency: push visible on out_valid the next cycle; credit_return is pop delayed by one cycle.
// Backpressure: out_ready stalls the head; the link has no ready, so a write while full without a pop is dropped and flagged.
module nebula_credit_rx_buffer #(
    parameter int FLIT_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [FLIT_WIDTH-1:0] in_flit,
    output logic                  out_valid,
    output logic [FLIT_WIDTH-1:0] out_flit,
    input  logic                  out_ready,
    output logic                  credit_return,
    output logic [CNT_WIDTH-1:0]  occupancy,
    output logic                  overflow_err,
    output logic [CNT_WIDTH-1:0]  high_water
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [FLIT_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_WIDTH-1:0]  count;
    logic [CNT_WIDTH-1:0]  count_nxt;
    logic                  full;
    logic                  pop;
    logic                  push;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full      = (count == CNT_WIDTH'(DEPTH));
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign push      = in_valid && (!full || pop);
    assign occupancy = count;
    assign out_flit  = out_valid ? mem[head] : '0;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_WIDTH'(1);
            2'b01:   count_nxt = count - CNT_WIDTH'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            credit_return <= 1'b0;
            overflow_err  <= 1'b0;
        end else begin
            if (push) tail <= ptr_inc(tail);
            if (pop)  head <= ptr_inc(head);
            count         <= count_nxt;
            credit_return <= pop;
            if (in_valid && full && !pop) overflow_err <= 1'b1;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst && push) mem[tail] <= in_flit;
    end

`ifdef NEBULA_RX_HWM_EN
    always_ff @(posedge clk) begin
        if (rst)
            high_water <= '0;
        else if (count_nxt > high_water)
            high_water <= count_nxt;
    end
`else
    assign high_water = '0;
`endif

endmodule

// File: tb/tb_nebula_credit_rx_buffer.sv
// Bench for nebula_credit_rx_buffer: directed vector table, HWM sequence, then random traffic vs a queue model.
module tb_nebula_credit_rx_buffer;
    localparam int FW = 8;
    localparam int DP = 4;
    localparam int CW = $clog2(DP + 1);
`ifdef NEBULA_RX_HWM_EN
    localparam bit HWM = 1'b1;
`else
    localparam bit HWM = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [FW-1:0] in_flit = '0;
    logic          out_valid;
    logic [FW-1:0] out_flit;
    logic          out_ready = 1'b0;
    logic          credit_return;
    logic [CW-1:0] occupancy;
    logic          overflow_err;
    logic [CW-1:0] high_water;

    nebula_credit_rx_buffer #(.FLIT_WIDTH(FW), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_flit(in_flit),
        .out_valid(out_valid), .out_flit(out_flit), .out_ready(out_ready),
        .credit_return(credit_return), .occupancy(occupancy),
        .overflow_err(overflow_err), .high_water(high_water)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: flit queue plus sticky flags.
    logic [FW-1:0] q[$];
    bit            m_cr  = 0;
    bit            m_ovf = 0;
    int            m_hw  = 0;
    bit            m_init = 0;

    typedef struct {
        logic          v;
        logic [FW-1:0] f;
        logic          r;
        logic          rs;
        int            occ;
        logic          vld;
        logic [FW-1:0] flit;
        logic          cr;
        logic          ovf;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic v, input logic [FW-1:0] f, input logic r, input logic rs);
        bit pop;
        if (rs) begin
            q.delete(); m_cr = 0; m_ovf = 0; m_hw = 0; m_init = 1;
        end else begin
            pop = (q.size() != 0) && r;
            if (pop) void'(q.pop_front());
            if (v) begin
                if (q.size() == DP) m_ovf = 1;
                else q.push_back(f);
            end
            m_cr = pop;
            if (HWM && q.size() > m_hw) m_hw = q.size();
        end
    endtask

    task automatic step(input logic v, input logic [FW-1:0] f, input logic r, input logic rs);
        @(negedge clk);
        in_valid = v; in_flit = f; out_ready = r; rst = rs;
        #1;
        if (m_init) begin
            chk("m_out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("m_out_flit", 32'(out_flit), (q.size() != 0) ? 32'(q[0]) : 32'd0);
            chk("m_occupancy", 32'(occupancy), 32'(q.size()));
            chk("m_credit_return", 32'(credit_return), 32'(m_cr));
            chk("m_overflow_err", 32'(overflow_err), 32'(m_ovf));
            chk("m_high_water", 32'(high_water), 32'(m_hw));
        end
        @(posedge clk);
        model_edge(v, f, r, rs);
    endtask

    function automatic vec_t mk(logic v, logic [FW-1:0] f, logic r, logic rs,
                                int occ, logic vld, logic [FW-1:0] flit, logic cr, logic ovf);
        vec_t e;
        e.v = v; e.f = f; e.r = r; e.rs = rs;
        e.occ = occ; e.vld = vld; e.flit = flit; e.cr = cr; e.ovf = ovf;
        return e;
    endfunction

    initial begin
        // Expected values are the outputs just after each vector's clock edge.
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 8'hA1, 0, 0, 1, 1, 8'hA1, 0, 0));
        tbl.push_back(mk(1, 8'hA2, 0, 0, 2, 1, 8'hA1, 0, 0));
        tbl.push_back(mk(1, 8'hA3, 0, 0, 3, 1, 8'hA1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 2, 1, 8'hA2, 1, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'hA3, 1, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 8'(8'hB0 + i), 0, 0, i + 1, 1, 8'hB0, 0, 0));
        tbl.push_back(mk(1, 8'hB4, 1, 0, 4, 1, 8'hB1, 1, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 3, 1, 8'hB2, 1, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 2, 1, 8'hB3, 1, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'hB4, 1, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 8'(8'hC1 + i), 0, 0, i + 1, 1, 8'hC1, 0, 0));
        tbl.push_back(mk(1, 8'hC5, 0, 0, 4, 1, 8'hC1, 0, 1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 3, 1, 8'hC2, 1, 1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 2, 1, 8'hC3, 1, 1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'hC4, 1, 1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0));
        // Reset while a pop is being requested: no credit for the discarded flits.
        tbl.push_back(mk(1, 8'hD1, 0, 0, 1, 1, 8'hD1, 0, 0));
        tbl.push_back(mk(1, 8'hD2, 0, 0, 2, 1, 8'hD1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0));

        foreach (tbl[k]) begin
            step(tbl[k].v, tbl[k].f, tbl[k].r, tbl[k].rs);
            #1;
            chk($sformatf("t%0d_occupancy", k), 32'(occupancy), 32'(tbl[k].occ));
            chk($sformatf("t%0d_out_valid", k), 32'(out_valid), 32'(tbl[k].vld));
            chk($sformatf("t%0d_out_flit", k), 32'(out_flit), 32'(tbl[k].flit));
            chk($sformatf("t%0d_credit_return", k), 32'(credit_return), 32'(tbl[k].cr));
            chk($sformatf("t%0d_overflow_err", k), 32'(overflow_err), 32'(tbl[k].ovf));
        end

        // High-water: fill to 3, drain, fill to 2.
        step(0, 8'h00, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 8'(8'hE0 + i), 0, 0);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0);
        for (int i = 0; i < 2; i++) step(1, 8'(8'hE8 + i), 0, 0);
        #1;
        chk("hwm_after_seq", 32'(high_water), HWM ? 32'd3 : 32'd0);

        // Randomized traffic, including senders that ignore credits and rare resets.
        for (int n = 0; n < 3000; n++) begin
            automatic int bias = (n / 500) % 3;
            automatic logic v  = ($urandom_range(0, 3) >= bias);
            automatic logic r  = ($urandom_range(0, 3) < 1 + bias);
            automatic logic rs = ($urandom_range(0, 199) == 0);
            step(v, 8'($urandom), r, rs);
        end
        step(0, 8'h00, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
